// File: rtl/exception_ctrl.sv
// Exception sequencer: EPC capture, cause, pipeline flush, handler redirect and ERET return.
// Latency: EPC strobe 1 cycle after exception, handler redirect after 2; no backpressure, inputs ignored mid-sequence.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter logic [4:0]  EXC_OVF      = 5'd12,
    parameter logic [4:0]  EXC_RI       = 5'd10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ovf_exc,
    input  logic        ri_exc,
    input  logic        eret,
    input  logic [31:0] exc_pc,
    input  logic [31:0] epc_in,
    output logic        epc_enable,
    output logic [31:0] epc_pc,
    output logic [31:0] cause,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        in_exception,
    output logic        double_fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_lat;
    logic [4:0]  exc_code;
    logic        dfault;
    logic        exc_any;

    assign exc_any = ovf_exc | ri_exc;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            pc_lat   <= 32'h0;
            exc_code <= 5'd0;
            dfault   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && exc_any) begin
                pc_lat   <= exc_pc;
                exc_code <= ovf_exc ? EXC_OVF : EXC_RI;
            end
            // A fault while the handler runs is only flagged; EPC and cause are preserved.
            if (state == HANDLER && exc_any)
                dfault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (exc_any) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = REDIRECT;
            REDIRECT: state_nxt = HANDLER;
            HANDLER:  if (eret) state_nxt = RETURN;
            RETURN:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        epc_enable   = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'h0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        in_exception = 1'b0;
        case (state)
            CAPTURE: begin
                epc_enable = 1'b1;
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                flush_ex   = 1'b1;
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                redirect_pc = HANDLER_ADDR;
                flush_if    = 1'b1;
            end
            HANDLER: in_exception = 1'b1;
            RETURN: begin
                pc_redirect  = 1'b1;
                redirect_pc  = epc_in;
                flush_if     = 1'b1;
                flush_id     = 1'b1;
                in_exception = 1'b1;
            end
            default: ;
        endcase
    end

    assign epc_pc       = pc_lat;
    assign cause        = {25'h0, exc_code, 2'b00};
    assign double_fault = dfault;

endmodule
